pipe_ex_mem: RTL
================

PIPE_EX_MEM -- requirements
Module: pipe_ex_mem

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the width of the instruction, address and store-data fields.
REQ-002 Parameter REG_W, default 3, SHALL set the width of the register-specifier fields.
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 stall  in  1  hazard-unit hold request for the EX/MEM register.
REQ-006 flush  in  1  branch/jump squash request; inserts a bubble.
REQ-007 valid  in  1  EX stage holds a real instruction.
REQ-008 instruction  in  DATA_W  EX-stage instruction word.
REQ-009 alu_result  in  DATA_W  EX result, also the memory address.
REQ-010 write_data  in  DATA_W  store data.
REQ-011 RD  in  REG_W  destination register; write_sel  in  REG_W  write-back select.
REQ-012 Reg_write, Mem_reg, Mem_read, Mem_write  in  1 each  control-unit signals from EX.
REQ-013 mem_done  in  1  data memory completion pulse for the current access.
REQ-014 valid_o, instruction_o, address_o, write_data_o, RD_o, write_sel_o, Reg_write_o, Mem_reg_o, Mem_read_o, Mem_write_o  out  registered copies feeding MEM and the MEM/WB register.
REQ-015 Mem_en_o  out  1  data memory enable.
REQ-016 mem_busy_o  out  1  combinational stall request to IF/ID/EX.

Function
REQ-017 hold = stall | mem_busy_o | (state==HELD); when hold is high, all registered outputs SHALL keep their values.
REQ-018 When hold is low and flush is high, or valid is low, the block SHALL load a bubble: valid_o and all control outputs 0, all data fields 0.
REQ-019 Otherwise the block SHALL load every input into its output, with address_o = alu_result, giving 1-cycle latency for non-memory instructions.
REQ-020 Flush SHALL take priority over stall only in IDLE; an access in ACCESS or HELD SHALL NOT be aborted by flush.
REQ-021 FSM states: IDLE, ACCESS, HELD.
REQ-022 IDLE -> ACCESS on any edge that loads valid with Mem_read or Mem_write set.
REQ-023 ACCESS -> IDLE on mem_done & ~stall; ACCESS -> HELD on mem_done & stall; otherwise remain in ACCESS.
REQ-024 HELD -> IDLE when stall is low.
REQ-025 Leaving ACCESS or HELD while a new memory instruction is loaded SHALL go directly to ACCESS, giving back-to-back accesses with no idle cycle.
REQ-026 Mem_en_o = (state==ACCESS); it SHALL be 0 in IDLE and HELD, so a completed access never re-issues.
REQ-027 mem_busy_o = (state==ACCESS) & ~mem_done.
REQ-028 mem_done SHALL be ignored in IDLE and HELD.

Reset
REQ-029 On rst high the block SHALL asynchronously clear every output register to 0 and force state to IDLE, including reset asserted mid-access.
REQ-030 With rst high, Mem_en_o and mem_busy_o SHALL be 0.

Structure
REQ-031 The FSM state encoding and the default widths (16, 3) SHALL live in the shared CPU package.
REQ-032 The memory-access FSM SHALL be one sub-module, mem_access_ctl; the field registers SHALL be built from the codebase dff cell, extended with an enable.

Verification
REQ-033 ADD (valid=1, Reg_write=1, alu_result=0x1234), no stall -> next cycle address_o=0x1234, Reg_write_o=1, Mem_en_o=0, mem_busy_o=0.
REQ-034 LD (Mem_read=1, address 0x0040), mem_done delayed 3 cycles -> Mem_en_o=1 and mem_busy_o=1 for 3 cycles, mem_busy_o=0 in the mem_done cycle, then IDLE.
REQ-035 ST completes while stall=1 for 2 cycles -> HELD for 2 cycles, Mem_en_o=0, outputs held, then the next instruction loads.
REQ-036 flush=1 with an ADD in IDLE -> valid_o=0, all controls 0; flush=1 during ACCESS -> ignored, access completes.
REQ-037 Two loads back-to-back -> the second is loaded on the first's mem_done edge and Mem_en_o stays 1 with no gap.
REQ-038 rst pulse mid-ACCESS, not clock-aligned -> all outputs 0 immediately, state IDLE, Mem_en_o=0.

Source files
------------

// File: rtl/pipe_ex_mem_pkg.sv
// Shared CPU package for the EX/MEM pipeline register.
// Holds the default field widths, the encoding of the memory-access FSM
// states, and a small decode helper.
package pipe_ex_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 3;

  // One-hot: each state is a single flop, so the FSM outputs come straight
  // from registers.
  typedef enum logic [2:0] {
    MEM_IDLE   = 3'b001,
    MEM_ACCESS = 3'b010,
    MEM_HELD   = 3'b100
  } mem_state_e;

  function automatic logic is_mem_op(input logic rd_op, input logic wr_op);
    return rd_op | wr_op;
  endfunction

endpackage

// File: rtl/dff_en.sv
// Codebase D flip-flop cell, W bits wide, with a load enable.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high clear
//   en   - load enable; q keeps its value when low
//   d/q  - data in / registered data out
module dff_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_ctl.sv
// Data-memory access sequencer for the EX/MEM stage.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   MEM_IDLE   | no access outstanding; EX/MEM register free to load
//   MEM_ACCESS | access issued, memory enabled, waiting for mem_done
//   MEM_HELD   | access finished while the pipeline was stalled; memory
//              | disabled so the completed access is not re-issued
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   stall     - hazard-unit hold request
//   mem_done  - completion pulse, only meaningful in MEM_ACCESS
//   load_mem  - a memory instruction is being loaded this edge
//   mem_en    - data memory enable
//   mem_busy  - access still in flight this cycle
//   in_idle   - FSM is in MEM_IDLE
//   in_held   - FSM is in MEM_HELD
module mem_access_ctl
  import pipe_ex_mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic mem_done,
  input  logic load_mem,
  output logic mem_en,
  output logic mem_busy,
  output logic in_idle,
  output logic in_held
);

  mem_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MEM_IDLE;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (load_mem) state <= MEM_ACCESS;
        end
        MEM_ACCESS: begin
          if (mem_done) begin
            if (stall)         state <= MEM_HELD;
            else if (load_mem) state <= MEM_ACCESS;
            else               state <= MEM_IDLE;
          end
        end
        MEM_HELD: begin
          if (!stall) state <= load_mem ? MEM_ACCESS : MEM_IDLE;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

  assign mem_en   = (state == MEM_ACCESS);
  assign mem_busy = mem_en & ~mem_done;
  assign in_idle  = (state == MEM_IDLE);
  assign in_held  = (state == MEM_HELD);

endmodule

// File: rtl/pipe_ex_mem.sv
// EX/MEM pipeline register with integrated data-memory access control.
// Captures the EX-stage instruction, result/address, store data, register
// specifiers and control bits; inserts bubbles on flush or invalid input;
// holds while stalled or while a memory access is outstanding.
//
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   stall, flush                 - hazard hold / branch squash requests
//   valid, instruction,
//   alu_result, write_data,
//   RD, write_sel, Reg_write,
//   Mem_reg, Mem_read, Mem_write - EX-stage inputs
//   mem_done                     - data memory completion pulse
//   *_o (fields)                 - registered copies for MEM and MEM/WB
//   address_o                    - registered alu_result, memory address
//   Mem_en_o                     - data memory enable
//   mem_busy_o                   - combinational stall request upstream
module pipe_ex_mem
  import pipe_ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [REG_W-1:0]  RD,
  input  logic [REG_W-1:0]  write_sel,
  input  logic              Reg_write,
  input  logic              Mem_reg,
  input  logic              Mem_read,
  input  logic              Mem_write,
  input  logic              mem_done,
  output logic              valid_o,
  output logic [DATA_W-1:0] instruction_o,
  output logic [DATA_W-1:0] address_o,
  output logic [DATA_W-1:0] write_data_o,
  output logic [REG_W-1:0]  RD_o,
  output logic [REG_W-1:0]  write_sel_o,
  output logic              Reg_write_o,
  output logic              Mem_reg_o,
  output logic              Mem_read_o,
  output logic              Mem_write_o,
  output logic              Mem_en_o,
  output logic              mem_busy_o
);

  localparam int FIELDS_W = 1 + 3 * DATA_W + 2 * REG_W + 4;

  logic                in_idle;
  logic                in_held;
  logic                hold;
  logic                load_en;
  logic                bubble;
  logic                load_mem;
  logic [FIELDS_W-1:0] fields_d;
  logic [FIELDS_W-1:0] fields_q;

  assign hold = stall | mem_busy_o | in_held;

  // A flush in IDLE beats a stall; once an access is in flight the hold
  // wins, so flush can never abort it.
  assign load_en  = ~hold | (flush & in_idle);
  assign bubble   = flush | ~valid;
  assign load_mem = load_en & ~bubble & is_mem_op(Mem_read, Mem_write);

  assign fields_d = bubble ? '0 :
                    {valid, instruction, alu_result, write_data, RD, write_sel,
                     Reg_write, Mem_reg, Mem_read, Mem_write};

  dff_en #(.W(FIELDS_W)) u_fields (
    .clk (clk),
    .rst (rst),
    .en  (load_en),
    .d   (fields_d),
    .q   (fields_q)
  );

  assign {valid_o, instruction_o, address_o, write_data_o, RD_o, write_sel_o,
          Reg_write_o, Mem_reg_o, Mem_read_o, Mem_write_o} = fields_q;

  mem_access_ctl u_ctl (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .mem_done (mem_done),
    .load_mem (load_mem),
    .mem_en   (Mem_en_o),
    .mem_busy (mem_busy_o),
    .in_idle  (in_idle),
    .in_held  (in_held)
  );

endmodule
